// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - decimating VGA frame grabber writing one 12-bit frame into image RAM
module vga_capture #(
    parameter int H_ACTIVE     = 640,
    parameter int H_BACK_PORCH = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_BACK_PORCH = 33,
    parameter int SCALE_LOG2   = 2,
    parameter int ADDR_W       = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vga_hsync_i,
    input  logic              vga_vsync_i,
    input  logic [3:0]        vga_red_i,
    input  logic [3:0]        vga_blue_i,
    input  logic [3:0]        vga_green_i,
    input  logic              capture_start_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [11:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o
);

    localparam int POS_W = 11;
    localparam logic [POS_W-1:0] POS_MAX  = {POS_W{1'b1}};
    localparam logic [POS_W-1:0] H_FIRST  = POS_W'(H_BACK_PORCH);
    localparam logic [POS_W-1:0] H_END    = POS_W'(H_BACK_PORCH + H_ACTIVE);
    localparam logic [POS_W-1:0] V_FIRST  = POS_W'(V_BACK_PORCH);
    localparam logic [POS_W-1:0] V_END    = POS_W'(V_BACK_PORCH + V_ACTIVE);
    localparam logic [POS_W-1:0] SUB_MASK = POS_W'((1 << SCALE_LOG2) - 1);
    localparam int FRAME_PIXELS = (H_ACTIVE >> SCALE_LOG2) * (V_ACTIVE >> SCALE_LOG2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    logic              hsync_q, hsync_qq, vsync_q, vsync_qq;
    logic [11:0]       rgb_q;
    logic              h_rise, v_rise, keep;
    logic [POS_W-1:0]  hcnt, lcnt, line_q;
    logic [POS_W-1:0]  hpos, line_cur, x_off, y_off;
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_cnt, addr_n;
    logic              full, full_n, err_n, wr_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_q  <= 1'b0;
            hsync_qq <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hsync_q  <= vga_hsync_i;
            hsync_qq <= hsync_q;
            vsync_q  <= vga_vsync_i;
            vsync_qq <= vsync_q;
            rgb_q    <= {vga_red_i, vga_blue_i, vga_green_i};
        end
    end

    assign h_rise = hsync_q & ~hsync_qq;
    assign v_rise = vsync_q & ~vsync_qq;

    // Position of the registered pixel; a line edge takes effect on its own cycle.
    always_comb begin
        hpos     = h_rise ? '0 : hcnt;
        line_cur = (h_rise && !v_rise) ? lcnt : line_q;
        x_off    = hpos - H_FIRST;
        y_off    = line_cur - V_FIRST;
        keep     = (hpos >= H_FIRST) && (hpos < H_END) &&
                   (line_cur >= V_FIRST) && (line_cur < V_END) &&
                   ((x_off & SUB_MASK) == '0) && ((y_off & SUB_MASK) == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt   <= '0;
            lcnt   <= '0;
            line_q <= '0;
        end else begin
            hcnt <= (hpos == POS_MAX) ? POS_MAX : hpos + POS_W'(1);
            if (v_rise) begin
                lcnt <= '0;
            end else if (h_rise) begin
                line_q <= lcnt;
                lcnt   <= (lcnt == POS_MAX) ? POS_MAX : lcnt + POS_W'(1);
            end
        end
    end

    // full blocks writes between issuing the last address and leaving CAPTURE.
    always_comb begin
        state_n = state;
        addr_n  = addr_cnt;
        full_n  = full;
        err_n   = frame_err_o;
        wr_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (capture_start_i) begin
                    state_n = S_ARM;
                    err_n   = 1'b0;
                end
            end
            S_ARM: begin
                if (v_rise) begin
                    state_n = S_CAPTURE;
                    addr_n  = '0;
                    full_n  = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (v_rise && !full) begin
                    err_n  = 1'b1;
                    addr_n = '0;
                end else if (keep && !full) begin
                    wr_n   = 1'b1;
                    addr_n = addr_cnt + ADDR_W'(1);
                    full_n = (addr_cnt == LAST_ADDR);
                end
                if (wr_en_o && (wr_addr_o == LAST_ADDR)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            addr_cnt    <= '0;
            full        <= 1'b0;
            frame_err_o <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
        end else begin
            state       <= state_n;
            addr_cnt    <= addr_n;
            full        <= full_n;
            frame_err_o <= err_n;
            wr_en_o     <= wr_n;
            if (wr_n) begin
                wr_addr_o <= addr_cnt;
                wr_data_o <= rgb_q;
            end
        end
    end

    assign busy_o = (state == S_ARM) || (state == S_CAPTURE);
    assign done_o = (state == S_DONE);

endmodule
